// File: rtl/bayer_pattern_source_if.sv
// Pixel-stream bundle between the Bayer pattern source and its consumer.
// The source drives the o* signals; the run controls i* come from the consumer side.
interface bayer_pattern_source_if;
    logic        iEN;
    logic [1:0]  iMODE;
    logic [11:0] iLEVEL;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic [10:0] oX_Cont;
    logic [10:0] oY_Cont;
    logic        oFVAL;
    logic [15:0] oFRAME_CNT;

    modport master (
        input  iEN, iMODE, iLEVEL,
        output oDATA, oDVAL, oX_Cont, oY_Cont, oFVAL, oFRAME_CNT
    );

    modport slave (
        output iEN, iMODE, iLEVEL,
        input  oDATA, oDVAL, oX_Cont, oY_Cont, oFVAL, oFRAME_CNT
    );
endinterface

// File: rtl/bayer_pattern_source.sv
// Camera-substitute Bayer raw stream: flat/ramp/checker/colour-bar frames with
// active, horizontal-blank and vertical-blank timing; all outputs registered.
module bayer_pattern_source #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_ACTIVE = 960,
    parameter int unsigned H_BLANK  = 64,
    parameter int unsigned V_BLANK  = 16
) (
    input  logic iCLK,
    input  logic iRST,
    bayer_pattern_source_if.master pix
);
    localparam int unsigned LINE_CYC = H_ACTIVE + H_BLANK;
    localparam int unsigned VB_CYC   = V_BLANK * LINE_CYC;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;
    localparam int unsigned CW       = $clog2(VB_CYC);
    localparam int unsigned BW       = $clog2(BAR_W + 1);

    localparam logic [10:0]   X_LAST   = 11'(H_ACTIVE - 1);
    localparam logic [10:0]   Y_LAST   = 11'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] VB_LAST  = CW'(VB_CYC - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

    state_t        state_q, state_d;
    logic [10:0]   x_q, x_d, y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    mode_q, mode_d;
    logic [11:0]   level_q, level_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [11:0]   data_q, data_d;
    logic          dval_q, dval_d;
    logic          fval_q, fval_d;
    logic          r_site, b_site, g_site, bar_on;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            mode_q      <= '0;
            level_q     <= '0;
            frame_cnt_q <= '0;
            data_q      <= '0;
            dval_q      <= 1'b0;
            fval_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            mode_q      <= mode_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            data_q      <= data_d;
            dval_q      <= dval_d;
            fval_q      <= fval_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        bar_cnt_d   = bar_cnt_q;
        bar_idx_d   = bar_idx_q;
        mode_d      = mode_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                x_d       = '0;
                y_d       = '0;
                cnt_d     = '0;
                bar_cnt_d = '0;
                bar_idx_d = '0;
                if (pix.iEN) begin
                    state_d = S_ACTIVE;
                    mode_d  = pix.iMODE;
                    level_d = pix.iLEVEL;
                end
            end
            S_ACTIVE: begin
                if (x_q == X_LAST) begin
                    state_d = S_HBLANK;
                    cnt_d   = '0;
                end else begin
                    x_d = x_q + 11'd1;
                    // Bar index advances every BAR_W columns, avoiding a divider.
                    if (bar_cnt_q == BAR_LAST) begin
                        bar_cnt_d = '0;
                        bar_idx_d = bar_idx_q + 3'd1;
                    end else begin
                        bar_cnt_d = bar_cnt_q + BW'(1);
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (y_q != Y_LAST) begin
                        state_d   = S_ACTIVE;
                        y_d       = y_q + 11'd1;
                        x_d       = '0;
                        bar_cnt_d = '0;
                        bar_idx_d = '0;
                    end else begin
                        state_d = S_VBLANK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    cnt_d       = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    x_d         = '0;
                    y_d         = '0;
                    bar_cnt_d   = '0;
                    bar_idx_d   = '0;
                    if (pix.iEN) begin
                        state_d = S_ACTIVE;
                        mode_d  = pix.iMODE;
                        level_d = pix.iLEVEL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output registers are loaded from next-state values so each sample
    // leaves together with its own column/row.
    always_comb begin
        r_site = ~y_d[0] &  x_d[0];
        b_site =  y_d[0] & ~x_d[0];
        g_site = ~(r_site | b_site);
        bar_on = (r_site & bar_idx_d[2]) | (g_site & bar_idx_d[1]) | (b_site & bar_idx_d[0]);
        dval_d = (state_d == S_ACTIVE);
        fval_d = dval_d | ((state_d == S_HBLANK) & (y_d != Y_LAST));
        data_d = '0;
        if (dval_d) begin
            case (mode_d)
                2'd0:    data_d = level_d;
                2'd1:    data_d = {x_d[9:0], 2'b00};
                2'd2:    data_d = (x_d[4] ^ y_d[4]) ? level_d : '0;
                default: data_d = bar_on ? '1 : '0;
            endcase
        end
    end

    assign pix.oDATA      = data_q;
    assign pix.oDVAL      = dval_q;
    assign pix.oX_Cont    = x_q;
    assign pix.oY_Cont    = y_q;
    assign pix.oFVAL      = fval_q;
    assign pix.oFRAME_CNT = frame_cnt_q;
endmodule

// File: tb/tb_bayer_pattern_source.sv
// Bench for bayer_pattern_source: small-frame timing/control/reset instance,
// wide-line ramp instance and 64-column colour-bar instance against a frame model.
module tb_bayer_pattern_source;
    localparam int unsigned AH  = 8;
    localparam int unsigned AV  = 4;
    localparam int unsigned AHB = 2;
    localparam int unsigned AVB = 3;
    localparam int unsigned AL  = AH + AHB;
    localparam int unsigned AF  = AV * AL + AVB * AL;
    localparam int unsigned RH  = 1280;
    localparam int unsigned BH  = 64;
    localparam int unsigned BL  = BH + 2;

    logic clk = 1'b0;
    logic rst_a, rst_r, rst_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bayer_pattern_source_if if_a ();
    bayer_pattern_source_if if_r ();
    bayer_pattern_source_if if_b ();

    bayer_pattern_source #(.H_ACTIVE(AH), .V_ACTIVE(AV), .H_BLANK(AHB), .V_BLANK(AVB))
        u_a (.iCLK(clk), .iRST(rst_a), .pix(if_a));
    bayer_pattern_source #(.H_ACTIVE(RH), .V_ACTIVE(2), .H_BLANK(4), .V_BLANK(1))
        u_r (.iCLK(clk), .iRST(rst_r), .pix(if_r));
    bayer_pattern_source #(.H_ACTIVE(BH), .V_ACTIVE(2), .H_BLANK(2), .V_BLANK(1))
        u_b (.iCLK(clk), .iRST(rst_b), .pix(if_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sample value from the pattern rules: sites G/R on even rows, B/G on odd rows.
    function automatic logic [11:0] model_pix(input int unsigned x, input int unsigned y,
                                              input int unsigned m, input int unsigned lv,
                                              input int unsigned h);
        int unsigned b, on;
        case (m)
            0: return 12'(lv);
            1: return 12'((x % 1024) * 4);
            2: return ((((x / 16) + (y / 16)) % 2) == 1) ? 12'(lv) : 12'h000;
            default: begin
                b = x / (h / 8);
                if (y % 2 == 0) on = (x % 2 == 0) ? (b / 2) % 2 : (b / 4) % 2;
                else            on = (x % 2 == 0) ? b % 2 : (b / 2) % 2;
                return (on != 0) ? 12'hFFF : 12'h000;
            end
        endcase
    endfunction

    task automatic chk_idle_a(input string tag, input int unsigned fc);
        chk({tag, "_dval"}, 32'(if_a.oDVAL), 0);
        chk({tag, "_fval"}, 32'(if_a.oFVAL), 0);
        chk({tag, "_x"},    32'(if_a.oX_Cont), 0);
        chk({tag, "_y"},    32'(if_a.oY_Cont), 0);
        chk({tag, "_data"}, 32'(if_a.oDATA), 0);
        chk({tag, "_fcnt"}, 32'(if_a.oFRAME_CNT), fc);
    endtask

    // One full frame of instance A; next-frame controls are driven during line 1.
    task automatic frame_a(input int unsigned m, input int unsigned lv, input int unsigned fc,
                           input int unsigned nm, input int unsigned nlv, input logic nen);
        int unsigned dv_n = 0, fv_n = 0;
        int unsigned line, col, ex, ey;
        logic edv, efv, hb;
        for (int unsigned t = 0; t < AF; t++) begin
            @(negedge clk);
            line = t / AL;
            col  = t % AL;
            hb   = 1'b0;
            if (t < AV * AL) begin
                edv = (col < AH);
                efv = edv || (line < AV - 1);
                hb  = !edv;
                ex  = edv ? col : AH - 1;
                ey  = line;
            end else begin
                edv = 1'b0;
                efv = 1'b0;
                ex  = 0;
                ey  = 0;
            end
            chk("a_dval", 32'(if_a.oDVAL), 32'(edv));
            chk("a_fval", 32'(if_a.oFVAL), 32'(efv));
            if (edv || hb) begin
                chk("a_x", 32'(if_a.oX_Cont), ex);
                chk("a_y", 32'(if_a.oY_Cont), ey);
            end
            if (edv) chk("a_data", 32'(if_a.oDATA), 32'(model_pix(ex, ey, m, lv, AH)));
            if (t < AF - 1) chk("a_fcnt", 32'(if_a.oFRAME_CNT), fc);
            dv_n += 32'(if_a.oDVAL);
            fv_n += 32'(if_a.oFVAL);
            if (t == AL + 1) begin
                if_a.iMODE  = 2'(nm);
                if_a.iLEVEL = 12'(nlv);
                if_a.iEN    = nen;
            end
        end
        chk("a_dval_cycles", dv_n, AV * AH);
        chk("a_fval_cycles", fv_n, AV * AH + (AV - 1) * AHB);
    endtask

    initial begin
        int unsigned m2, lv2, m3, lv3, m4, lv4, m5, lv5, lvr;
        rst_a = 1'b0; rst_r = 1'b0; rst_b = 1'b0;
        if_a.iEN = 1'b0; if_a.iMODE = '0; if_a.iLEVEL = '0;
        if_r.iEN = 1'b0; if_r.iMODE = '0; if_r.iLEVEL = '0;
        if_b.iEN = 1'b0; if_b.iMODE = '0; if_b.iLEVEL = '0;
        lv2 = $urandom_range(4095, 0);
        m3  = $urandom_range(3, 0);  lv3 = $urandom_range(4095, 0);
        m4  = $urandom_range(3, 0);  lv4 = $urandom_range(4095, 0);
        m5  = $urandom_range(3, 0);  lv5 = $urandom_range(4095, 0);
        lvr = $urandom_range(4095, 0);
        m2  = 2;

        repeat (3) @(negedge clk);
        chk_idle_a("reset", 0);
        rst_a = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_idle_a("idle_en0", 0);
        end

        // Flat frame; checker request arrives mid-frame and must wait.
        if_a.iEN = 1'b1; if_a.iMODE = 2'd0; if_a.iLEVEL = 12'h5A5;
        frame_a(0, 12'h5A5, 0, m2, lv2, 1'b1);
        // Checker frame; iEN dropped on line 1, frame still completes.
        frame_a(m2, lv2, 1, m3, lv3, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk_idle_a("idle_after_drop", 2);
        end

        if_a.iEN = 1'b1;
        frame_a(m3, lv3, 2, m4, lv4, 1'b1);

        // Asynchronous reset in the middle of line 0 at X=5.
        for (int unsigned t = 0; t <= 5; t++) @(negedge clk);
        chk("rst_pre_x", 32'(if_a.oX_Cont), 5);
        #1 rst_a = 1'b0;
        #1 chk_idle_a("rst_async", 0);
        @(negedge clk);
        chk_idle_a("rst_held", 0);
        if_a.iMODE = 2'(m5); if_a.iLEVEL = 12'(lv5);
        rst_a = 1'b1;
        frame_a(m5, lv5, 0, 0, 0, 1'b1);
        if_a.iEN = 1'b0;

        // Ramp across a 1280-pixel line, including the wrap at x=1024.
        rst_r = 1'b1;
        @(negedge clk);
        if_r.iEN = 1'b1; if_r.iMODE = 2'd1; if_r.iLEVEL = 12'(lvr);
        for (int unsigned t = 0; t < RH; t++) begin
            @(negedge clk);
            chk("r_dval", 32'(if_r.oDVAL), 1);
            chk("r_x", 32'(if_r.oX_Cont), t);
            chk("r_data", 32'(if_r.oDATA), 32'(model_pix(t, 0, 1, lvr, RH)));
            if (t == 3)    chk("ramp_x3",    32'(if_r.oDATA), 32'h00C);
            if (t == 1023) chk("ramp_x1023", 32'(if_r.oDATA), 32'hFFC);
            if (t == 1024) chk("ramp_x1024", 32'(if_r.oDATA), 32'h000);
        end
        @(negedge clk);
        chk("r_hblank_dval", 32'(if_r.oDVAL), 0);

        // Colour bars over the first two lines of a 64-column frame.
        rst_b = 1'b1;
        @(negedge clk);
        if_b.iEN = 1'b1; if_b.iMODE = 2'd3; if_b.iLEVEL = 12'(lvr);
        for (int unsigned t = 0; t < BL + BH; t++) begin
            int unsigned col, line;
            @(negedge clk);
            col  = t % BL;
            line = t / BL;
            if (col < BH) begin
                chk("b_dval", 32'(if_b.oDVAL), 1);
                chk("b_x", 32'(if_b.oX_Cont), col);
                chk("b_y", 32'(if_b.oY_Cont), line);
                chk("b_data", 32'(if_b.oDATA), 32'(model_pix(col, line, 3, lvr, BH)));
                if (line == 0 && col == 1)  chk("bars_x1_y0",  32'(if_b.oDATA), 32'h000);
                if (line == 0 && col == 33) chk("bars_x33_y0", 32'(if_b.oDATA), 32'hFFF);
                if (line == 1 && col == 16) chk("bars_x16_y1", 32'(if_b.oDATA), 32'h000);
                if (line == 1 && col == 56) chk("bars_x56_y1", 32'(if_b.oDATA), 32'hFFF);
            end else begin
                chk("b_hblank_dval", 32'(if_b.oDVAL), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
